// File: rtl/cpu5_dmem_resp.sv
// ---------------------------------------------------------------------------
// cpu5_dmem_resp
// Data-memory responder for the CPU5 core. It accepts one load/store at a
// time over a valid/ready request channel, waits WAIT_CYCLES cycles, then
// presents a response that is held until the initiator consumes it.
// Stores commit on the edge that enters RESP. Loads capture data on that same
// edge, which is before any write on that edge takes effect. A misaligned or
// out-of-range access reports rsp_err and leaves the array untouched.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (array is not cleared)
//   req_valid  in   request present
//   req_ready  out  high only in IDLE
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address (XLEN)
//   req_wdata  in   store data (XLEN)
//   req_wstrb  in   store byte-lane enables, lane i = bits [8i+7:8i]
//   rsp_valid  out  response available
//   rsp_ready  in   initiator consumes the response
//   rsp_rdata  out  load data; 0 for stores, errors and when idle
//   rsp_err    out  misaligned or out-of-range access
// ---------------------------------------------------------------------------
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

module cpu5_dmem_resp #(
  parameter int XLEN        = `CPU5_XLEN,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [XLEN-3:0] DEPTH_IDX = (XLEN-2)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            accept_s;
  logic            enter_resp_s;
  logic            eff_write_s;
  logic [XLEN-1:0] eff_addr_s, eff_wdata_s;
  logic [3:0]      eff_wstrb_s;
  logic            err_s;
  logic [AW-1:0]   idx_s;
  logic [XLEN-1:0] rd_word_s, merged_s;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access must be decoded from the live request instead of the latched copy.
  always_comb begin
    enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
    if (state_q == ST_IDLE) begin
      eff_write_s = req_write;
      eff_addr_s  = req_addr;
      eff_wdata_s = req_wdata;
      eff_wstrb_s = req_wstrb;
    end else begin
      eff_write_s = write_q;
      eff_addr_s  = addr_q;
      eff_wdata_s = wdata_q;
      eff_wstrb_s = wstrb_q;
    end
    err_s     = (eff_addr_s[1:0] != 2'b00) || (eff_addr_s[XLEN-1:2] >= DEPTH_IDX);
    idx_s     = eff_addr_s[AW+1:2];
    rd_word_s = mem_q[idx_s];
  end

  // Byte-lane merge of store data over the current word.
  always_comb begin
    merged_s = rd_word_s;
    for (int i = 0; i < 4; i++) begin
      if (eff_wstrb_s[i]) begin
        merged_s[8*i +: 8] = eff_wdata_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on accept; later input changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'd0;
    end else if (accept_s) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end else begin
      write_q <= write_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
      wstrb_q <= wstrb_q;
    end
  end

  // Response data/error: loaded entering RESP, cleared when consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp_s) begin
      err_q   <= err_s;
      rdata_q <= (err_s || eff_write_s) ? '0 : rd_word_s;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_q;
      err_q   <= err_q;
    end
  end

  // Storage array: not reset, so contents survive reset. The reset term keeps
  // a zero-wait accept from committing while reset is held low.
  always_ff @(posedge clk) begin
    if (reset && enter_resp_s && eff_write_s && !err_s) begin
      mem_q[idx_s] <= merged_s;
    end else begin
      mem_q[idx_s] <= mem_q[idx_s];
    end
  end

endmodule
